adc_spi_sampler: RTL and testbench

- Upstream acquisition stage for the data collector.
- Runs one SPI conversion frame on the MIKROE-340 board's MCP3204 12-bit ADC for each start request, using a 100 kHz serial clock derived from the 50 MHz clk.
- Delivers the result on `sample` with a one-cycle `sample_valid` strobe.
- The collector's storage logic consumes `sample` / `sample_valid`, then hands the buffer to the Arduino writer.

---
 rtl/adc_spi_sampler_pkg.sv | 29 ++
 rtl/adc_spi_sampler_sck_gen.sv | 51 +++++
 rtl/adc_spi_sampler.sv | 163 ++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_sampler_pkg.sv
// Shared types and frame constants for the MCP3204 SPI sampler.
package adc_sampler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone,
        StGap
    } state_e;

    localparam int unsigned     EDGE_W          = 5;
    localparam logic [EDGE_W-1:0] FRAME_SCK     = 5'd19;
    localparam logic [EDGE_W-1:0] FIRST_DATA_EDGE = 5'd8;
    localparam logic [EDGE_W-1:0] CMD_BITS      = 5'd5;
    localparam logic            START_BIT       = 1'b1;
    localparam logic            SGL_BIT         = 1'b1;
    localparam int unsigned     AVG_FRAMES      = 4;

    // Command bit driven during SCK period `period` (1-based); zero after the command.
    function automatic logic cmd_bit(input logic [2:0] channel, input logic [EDGE_W-1:0] period);
        logic [4:0] cmd;
        cmd = {START_BIT, SGL_BIT, channel};
        if (period == '0 || period > CMD_BITS) begin
            return 1'b0;
        end
        return cmd[3'(CMD_BITS - period)];
    endfunction

endpackage

// File: rtl/adc_spi_sampler_sck_gen.sv
// SCK generator: CLK_DIV-cycle half periods, rise/fall strobes and a rising-edge counter.
module sck_gen
    import adc_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    output logic              o_sck,
    output logic              o_rise,
    output logic              o_fall,
    output logic [EDGE_W-1:0] o_edge_cnt
);

    localparam int unsigned      CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_sck;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              w_wrap;

    // Strobes mark the clk edge at which the registered sck toggles.
    assign w_wrap     = i_en && (r_cnt == CNT_MAX);
    assign o_rise     = w_wrap && !r_sck;
    assign o_fall     = w_wrap && r_sck;
    assign o_sck      = r_sck;
    assign o_edge_cnt = r_edge_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_sck      <= 1'b0;
            r_edge_cnt <= '0;
        end else if (!i_en) begin
            r_cnt      <= '0;
            r_sck      <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_sck <= !r_sck;
            end
            if (o_rise) begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: one MCP3204 SPI frame per start, 12-bit result with a one-cycle strobe.
// Define ADC_AVG_EN to run four frames per start and report their truncated mean.
module adc_spi_sampler
    import adc_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250,
    parameter logic [2:0]  CHANNEL = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_cs_n,
    output logic        o_sck,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic [11:0] o_sample,
    output logic        o_sample_valid
);

    localparam int unsigned      GAP_W   = $clog2(2 * CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(2 * CLK_DIV - 2);

    state_e            r_state, w_state_d;
    logic              r_cs_n, w_cs_n_d;
    logic              r_mosi, w_mosi_d;
    logic [11:0]       r_shift, w_shift_d;
    logic [11:0]       r_sample, w_sample_d;
    logic              r_valid, w_valid_d;
    logic [GAP_W-1:0]  r_gap, w_gap_d;
    logic              w_sck_en, w_rise, w_fall;
    logic [EDGE_W-1:0] w_edge_cnt;

`ifdef ADC_AVG_EN
    localparam logic [1:0] LAST_FRAME = 2'(AVG_FRAMES - 1);
    logic [13:0] r_acc, w_acc_d, w_sum;
    logic [1:0]  r_frame, w_frame_d;
    assign w_sum = r_acc + {2'b00, r_shift};
`endif

    assign w_sck_en = (r_state == StShift);

    sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_sck_en),
        .o_sck      (o_sck),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_edge_cnt (w_edge_cnt)
    );

    always_comb begin
        w_state_d  = r_state;
        w_cs_n_d   = r_cs_n;
        w_mosi_d   = r_mosi;
        w_shift_d  = r_shift;
        w_sample_d = r_sample;
        w_valid_d  = 1'b0;
        w_gap_d    = r_gap;
`ifdef ADC_AVG_EN
        w_acc_d    = r_acc;
        w_frame_d  = r_frame;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StShift;
                    w_cs_n_d  = 1'b0;
                    w_mosi_d  = START_BIT;
                    w_shift_d = '0;
`ifdef ADC_AVG_EN
                    w_acc_d   = '0;
                    w_frame_d = '0;
`endif
                end
            end
            StShift: begin
                // Edges before FIRST_DATA_EDGE carry command/null bits only.
                if (w_rise && w_edge_cnt >= FIRST_DATA_EDGE - 5'd1) begin
                    w_shift_d = {r_shift[10:0], i_miso};
                end
                if (w_fall) begin
                    if (w_edge_cnt == FRAME_SCK) begin
                        w_state_d = StDone;
                        w_cs_n_d  = 1'b1;
                        w_mosi_d  = 1'b0;
`ifdef ADC_AVG_EN
                        w_acc_d = w_sum;
                        if (r_frame == LAST_FRAME) begin
                            w_sample_d = w_sum[13:2];
                            w_valid_d  = 1'b1;
                        end
`else
                        w_sample_d = r_shift;
                        w_valid_d  = 1'b1;
`endif
                    end else begin
                        w_mosi_d = cmd_bit(CHANNEL, w_edge_cnt + 5'd1);
                    end
                end
            end
            StDone: begin
                w_state_d = StGap;
                w_gap_d   = '0;
            end
            StGap: begin
                if (r_gap == GAP_MAX) begin
                    w_state_d = StIdle;
`ifdef ADC_AVG_EN
                    if (r_frame != LAST_FRAME) begin
                        w_state_d = StShift;
                        w_cs_n_d  = 1'b0;
                        w_mosi_d  = START_BIT;
                        w_shift_d = '0;
                        w_frame_d = r_frame + 2'd1;
                    end
`endif
                end else begin
                    w_gap_d = r_gap + 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cs_n   <= 1'b1;
            r_mosi   <= 1'b0;
            r_shift  <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_gap    <= '0;
`ifdef ADC_AVG_EN
            r_acc    <= '0;
            r_frame  <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_cs_n   <= w_cs_n_d;
            r_mosi   <= w_mosi_d;
            r_shift  <= w_shift_d;
            r_sample <= w_sample_d;
            r_valid  <= w_valid_d;
            r_gap    <= w_gap_d;
`ifdef ADC_AVG_EN
            r_acc    <= w_acc_d;
            r_frame  <= w_frame_d;
`endif
        end
    end

    assign o_busy         = (r_state != StIdle);
    assign o_cs_n         = r_cs_n;
    assign o_mosi         = r_mosi;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler: a slow default-rate DUT and a fast CLK_DIV=2 DUT.
module tb_adc_spi_sampler;

    localparam int unsigned DIV0 = 250;
    localparam int unsigned DIV1 = 2;
    localparam logic [2:0]  CH0  = 3'd3;
    localparam logic [2:0]  CH1  = 3'd5;
`ifdef ADC_AVG_EN
    localparam int unsigned NFR = 4;
`else
    localparam int unsigned NFR = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  miso = 2'b00;
    logic [1:0]  busy, cs_n, sck, mosi, valid;
    logic [11:0] sample [2];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    // Device response and expected-result queues (ring buffers, never wrap in this run).
    logic [11:0] dev_mem [2][256];
    int          dev_wr [2];
    int          dev_rd [2];
    logic [11:0] exp_val [2][256];
    int unsigned exp_cyc [2][256];
    int          exp_wr [2];
    int          exp_rd [2];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_sampler #(.CLK_DIV(DIV0), .CHANNEL(CH0)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_cs_n(cs_n[0]),
        .o_sck(sck[0]), .o_mosi(mosi[0]), .i_miso(miso[0]), .o_sample(sample[0]),
        .o_sample_valid(valid[0])
    );

    adc_spi_sampler #(.CLK_DIV(DIV1), .CHANNEL(CH1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_cs_n(cs_n[1]),
        .o_sck(sck[1]), .o_mosi(mosi[1]), .i_miso(miso[1]), .o_sample(sample[1]),
        .o_sample_valid(valid[1])
    );

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    function automatic logic [2:0] ch_of(input int d);
        return (d == 0) ? CH0 : CH1;
    endfunction

    // Reference: mean of the NFR frame results, truncated.
    function automatic logic [11:0] expect_of(input logic [47:0] v);
        int unsigned s;
        s = 0;
        for (int i = 0; i < int'(NFR); i++) s += int'(v[i*12 +: 12]);
        return 12'(s / NFR);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Behavioural MCP3204 plus output monitor, sampled on the falling clk edge.
    logic [1:0]  prev_cs = 2'b11;
    logic [1:0]  prev_sck = 2'b00;
    int          rises [2];
    int unsigned hi_cnt [2];
    logic [18:0] cmd [2];
    logic [11:0] cur [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                prev_cs[d]  = 1'b1;
                prev_sck[d] = 1'b0;
                hi_cnt[d]   = 1000;
                rises[d]    = 0;
                miso[d]     = 1'b0;
            end else begin
                if (prev_cs[d] && !cs_n[d]) begin
                    check("cs_high_gap", 32'(hi_cnt[d] >= 2 * div_of(d)), 32'd1);
                    rises[d] = 0;
                    cmd[d]   = '0;
                    miso[d]  = 1'b0;
                    if (dev_rd[d] < dev_wr[d]) begin
                        cur[d] = dev_mem[d][dev_rd[d]];
                        dev_rd[d]++;
                    end else begin
                        cur[d] = '0;
                        fail_now("dev_underrun");
                    end
                end
                if (!prev_sck[d] && sck[d]) begin
                    rises[d]++;
                    cmd[d] = {cmd[d][17:0], mosi[d]};
                end
                // After falling edge f the device presents B(18-f) for rising edge f+1.
                if (prev_sck[d] && !sck[d] && rises[d] >= 7 && rises[d] <= 18)
                    miso[d] = cur[d][4'(18 - rises[d])];
                if (!prev_cs[d] && cs_n[d]) begin
                    check("sck_rises", 32'(rises[d]), 32'd19);
                    check("cmd_bits", 32'(cmd[d]), 32'({1'b1, 1'b1, ch_of(d), 14'b0}));
                end
                if (valid[d]) begin
                    if (exp_rd[d] < exp_wr[d]) begin
                        check("sample", 32'(sample[d]), 32'(exp_val[d][exp_rd[d]]));
                        check("valid_cycle", cyc, exp_cyc[d][exp_rd[d]]);
                        exp_rd[d]++;
                    end else begin
                        fail_now("unexpected_valid");
                    end
                end
                hi_cnt[d]   = cs_n[d] ? hi_cnt[d] + 1 : 0;
                prev_cs[d]  = cs_n[d];
                prev_sck[d] = sck[d];
            end
        end
    end

    task automatic push_frames(input int d, input logic [47:0] v, input int unsigned vcyc);
        for (int i = 0; i < int'(NFR); i++) begin
            dev_mem[d][dev_wr[d]] = v[i*12 +: 12];
            dev_wr[d]++;
        end
        exp_val[d][exp_wr[d]] = expect_of(v);
        exp_cyc[d][exp_wr[d]] = vcyc;
        exp_wr[d]++;
    endtask

    task automatic wait_idle(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50000 && !ok; i++) begin
            @(negedge clk);
            if (!busy[d]) ok = 1'b1;
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    // One start; optionally pulse start again mid-frame, which must be ignored.
    task automatic convert(input int d, input logic [47:0] v, input bit poke);
        bit          ok;
        int unsigned t0;
        wait_idle(d, ok);
        if (!ok) return;
        t0 = cyc;
        push_frames(d, v, t0 + 1 + (40 * NFR - 2) * div_of(d));
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check("cs_n_low_t0p1", 32'(cs_n[d]), 32'd0);
        check("busy_high_t0p1", 32'(busy[d]), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50000 && !ok; i++) begin
            start[d] = (poke && cyc == t0 + 2999);
            @(negedge clk);
            if (!busy[d]) ok = 1'b1;
        end
        start[d] = 1'b0;
        if (ok) check("busy_fall_cycle", cyc, t0 + 1 + 40 * NFR * div_of(d));
        else fail_now("busy_fall_timeout");
    endtask

    // start held high for n accepted requests: back-to-back sequences with full gaps.
    task automatic continuous(input int d, input int n);
        bit          ok;
        int unsigned t0, period;
        int          acc;
        wait_idle(d, ok);
        if (!ok) return;
        t0     = cyc;
        period = 40 * NFR * div_of(d) + 1;
        for (int k = 0; k < n; k++)
            push_frames(d, 48'({$urandom, $urandom}),
                        t0 + k * period + 1 + (40 * NFR - 2) * div_of(d));
        start[d] = 1'b1;
        acc = 0;
        ok  = 1'b0;
        for (int i = 0; i < n * int'(period) + 50 && !ok; i++) begin
            if (!busy[d]) begin
                acc++;
                if (acc == n) ok = 1'b1;
            end
            if (!ok) @(negedge clk);
        end
        if (!ok) fail_now("continuous_timeout");
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic reset_mid_frame();
        bit ok;
        wait_idle(1, ok);
        if (!ok) return;
        dev_mem[1][dev_wr[1]] = 12'h5A5;
        dev_wr[1]++;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (rises[1] >= 10) ok = 1'b1;
        end
        if (!ok) begin
            fail_now("edge10_timeout");
            return;
        end
        #3 rst = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(cs_n[1]), 32'd1);
        check("rst_mid_sck", 32'(sck[1]), 32'd0);
        check("rst_mid_busy", 32'(busy[1]), 32'd0);
        check("rst_mid_mosi", 32'(mosi[1]), 32'd0);
        check("rst_mid_sample", 32'(sample[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dev_wr[1] = dev_rd[1];
    endtask

    initial begin
        #15;
        for (int d = 0; d < 2; d++) begin
            check("reset_cs_n", 32'(cs_n[d]), 32'd1);
            check("reset_sck", 32'(sck[d]), 32'd0);
            check("reset_mosi", 32'(mosi[d]), 32'd0);
            check("reset_busy", 32'(busy[d]), 32'd0);
            check("reset_sample", 32'(sample[d]), 32'd0);
            check("reset_valid", 32'(valid[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        convert(0, {4{12'hA5C}}, 1'b1);
        convert(1, {4{12'h000}}, 1'b0);
        convert(1, {4{12'hFFF}}, 1'b0);
        convert(1, {12'd103, 12'd102, 12'd101, 12'd100}, 1'b0);
        repeat (5) convert(1, 48'({$urandom, $urandom}), 1'b0);
        reset_mid_frame();
        convert(1, 48'({$urandom, $urandom}), 1'b0);
        continuous(1, 4);

        repeat (400) @(negedge clk);
        for (int d = 0; d < 2; d++) check("scoreboard_drained", 32'(exp_rd[d]), 32'(exp_wr[d]));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
